sdhci_cmd_ctrl: RTL and testbench

SDHCI_CMD_CTRL -- requirements
Module: sdhci_cmd_ctrl

---
 rtl/sdhci_pkg.sv | 29 ++
 rtl/sdhci_crc7.sv | 25 ++
 rtl/sdhci_cmd_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sdhci_cmd_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdhci_pkg.sv
// Shared types and constants for the SDHCI command-line controller.
package sdhci_pkg;

    typedef enum logic [1:0] {
        RESP_NONE      = 2'd0,
        RESP_R48       = 2'd1,
        RESP_R136      = 2'd2,
        RESP_R48_NOCRC = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    localparam int unsigned CMD_LEN  = 48;
    localparam int unsigned R48_LEN  = 48;
    localparam int unsigned R136_LEN = 136;
    // Leading frame bits protected by CRC7 in commands and R48 replies.
    localparam int unsigned CRC_SPAN = 40;
    // R136 leading bits (start, transmission, reserved) outside the CRC.
    localparam int unsigned R136_CRC_SKIP = 8;
    // x^7 + x^3 + 1 with the x^7 term implicit.
    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sdhci_crc7.sv
// Bit-serial CRC7 engine; clear has priority over enable.
module sdhci_crc7
    import sdhci_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic fb;

    assign fb = bit_i ^ crc_o[6];

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            crc_o <= '0;
        end else if (en_i) begin
            crc_o <= {crc_o[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sdhci_cmd_ctrl.sv
// SD CMD-line controller: serialises a command, collects the response,
// checks CRC/end bit, then enforces the idle gap before the next command.
module sdhci_cmd_ctrl
    import sdhci_pkg::*;
#(
    parameter int unsigned TimeoutTicks = 64,
    parameter int unsigned GapTicks     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sd_tick_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         end_err_o,
    output logic [119:0] resp_o
);

    localparam int unsigned TICK_MAX = (TimeoutTicks > GapTicks) ? TimeoutTicks : GapTicks;
    localparam int unsigned TW       = $clog2(TICK_MAX + 1);
    localparam int unsigned BW       = 8;

    state_e       state, state_d;
    resp_type_e   cmd_type;
    logic [39:0]  tx_sr;
    logic [126:0] rx_sr;
    logic [127:0] rx_sr_n;
    logic [BW-1:0] bit_cnt, rx_last;
    logic [TW-1:0] tick_cnt;
    logic [6:0]   crc;
    logic [2:0]   crc_idx;
    logic         accept, send_done, wait_to, rx_done, gap_done;
    logic         tx_bit, cmd_d, done_d;
    logic         crc_clr, crc_en, crc_bit;

    assign accept    = (state == ST_IDLE) && start_i && !abort_i;
    assign rx_last   = (cmd_type == RESP_R136) ? BW'(R136_LEN - 1) : BW'(R48_LEN - 1);
    assign send_done = sd_tick_i && (bit_cnt == BW'(CMD_LEN));
    assign wait_to   = (tick_cnt == TW'(TimeoutTicks - 1));
    assign rx_done   = sd_tick_i && (bit_cnt == rx_last);
    assign gap_done  = sd_tick_i && (tick_cnt == TW'(GapTicks - 1));
    assign rx_sr_n   = {rx_sr, cmd_i};
    assign crc_idx   = 3'(BW'(CMD_LEN - 2) - bit_cnt);

    // State register with registered CMD-line and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            cmd_o    <= 1'b1;
            cmd_oe_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_d;
            cmd_o    <= cmd_d;
            cmd_oe_o <= (state_d == ST_SEND);
            busy_o   <= (state_d != ST_IDLE);
            done_o   <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start_i) state_d = ST_SEND;
                ST_SEND: if (send_done) state_d = (cmd_type == RESP_NONE) ? ST_GAP : ST_WAIT;
                ST_WAIT: if (sd_tick_i) begin
                    if (!cmd_i)       state_d = ST_RECV;
                    else if (wait_to) state_d = ST_GAP;
                end
                ST_RECV: if (rx_done) state_d = ST_GAP;
                ST_GAP:  if (gap_done) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Frame bit order: 40 payload bits, then CRC7 MSB first, then the end bit.
    always_comb begin
        tx_bit = 1'b1;
        if (bit_cnt < BW'(CRC_SPAN))         tx_bit = tx_sr[39];
        else if (bit_cnt < BW'(CMD_LEN - 1)) tx_bit = crc[crc_idx];
        cmd_d = cmd_o;
        if (state_d != ST_SEND)                   cmd_d = 1'b1;
        else if (state == ST_SEND && sd_tick_i)   cmd_d = tx_bit;
        done_d = (state == ST_GAP) && gap_done && !abort_i;
    end

    // One CRC engine: fed by outgoing bits in SEND, by sampled bits on receive.
    always_comb begin
        crc_clr = accept || ((state == ST_SEND) && send_done);
        crc_en  = 1'b0;
        crc_bit = cmd_i;
        case (state)
            ST_SEND: if (sd_tick_i && (bit_cnt < BW'(CRC_SPAN))) begin
                crc_en  = 1'b1;
                crc_bit = tx_sr[39];
            end
            ST_WAIT: crc_en = sd_tick_i && !cmd_i && (cmd_type != RESP_R136);
            ST_RECV: if (sd_tick_i) begin
                if (cmd_type == RESP_R136)
                    crc_en = (bit_cnt >= BW'(R136_CRC_SKIP)) && (bit_cnt <= BW'(R136_LEN - R136_CRC_SKIP - 1));
                else
                    crc_en = (bit_cnt < BW'(CRC_SPAN));
            end
            default: ;
        endcase
    end

    sdhci_crc7 u_crc7 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (crc_bit),
        .crc_o (crc)
    );

    // Datapath: shift registers, counters, flags and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_type      <= RESP_NONE;
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            tick_cnt      <= '0;
            timeout_err_o <= 1'b0;
            crc_err_o     <= 1'b0;
            end_err_o     <= 1'b0;
            resp_o        <= '0;
        end else if (!abort_i) begin
            case (state)
                ST_IDLE: if (start_i) begin
                    cmd_type      <= resp_type_e'(resp_type_i);
                    tx_sr         <= {2'b01, cmd_index_i, cmd_arg_i};
                    bit_cnt       <= '0;
                    tick_cnt      <= '0;
                    timeout_err_o <= 1'b0;
                    crc_err_o     <= 1'b0;
                    end_err_o     <= 1'b0;
                end
                ST_SEND: if (sd_tick_i) begin
                    if (send_done) begin
                        bit_cnt  <= '0;
                        tick_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        tx_sr   <= {tx_sr[38:0], 1'b0};
                    end
                end
                ST_WAIT: if (sd_tick_i) begin
                    if (!cmd_i) begin
                        rx_sr    <= rx_sr_n[126:0];
                        bit_cnt  <= BW'(1);
                        tick_cnt <= '0;
                    end else if (wait_to) begin
                        timeout_err_o <= 1'b1;
                        tick_cnt      <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                ST_RECV: if (sd_tick_i) begin
                    rx_sr   <= rx_sr_n[126:0];
                    bit_cnt <= bit_cnt + BW'(1);
                    if (rx_done) begin
                        bit_cnt   <= '0;
                        resp_o    <= (cmd_type == RESP_R136) ? rx_sr_n[127:8] : {88'b0, rx_sr_n[39:8]};
                        crc_err_o <= (cmd_type != RESP_R48_NOCRC) && (crc != rx_sr_n[7:1]);
                        end_err_o <= !rx_sr_n[0];
                    end
                end
                ST_GAP: if (sd_tick_i) begin
                    tick_cnt <= gap_done ? '0 : tick_cnt + TW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdhci_cmd_ctrl.sv
// Directed bench for sdhci_cmd_ctrl: command streams, responses, errors, abort, reset.
module tb_sdhci_cmd_ctrl;

    logic         clk = 1'b0;
    logic         rst, sd_tick, start, abort, cmd_in;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   typ;
    logic         cmd_out, cmd_oe, busy, done, t_err, c_err, e_err;
    logic [119:0] resp;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    sdhci_cmd_ctrl #(.TimeoutTicks(64), .GapTicks(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sd_tick_i     (sd_tick),
        .start_i       (start),
        .abort_i       (abort),
        .cmd_index_i   (idx),
        .cmd_arg_i     (arg),
        .resp_type_i   (typ),
        .cmd_i         (cmd_in),
        .cmd_o         (cmd_out),
        .cmd_oe_o      (cmd_oe),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_err_o (t_err),
        .crc_err_o     (c_err),
        .end_err_o     (e_err),
        .resp_o        (resp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic cin);
        sd_tick = 1'b0;
        step();
        step();
        cmd_in  = cin;
        sd_tick = 1'b1;
        step();
        sd_tick = 1'b0;
    endtask

    task automatic start_cmd(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t,
                             input logic with_tick);
        idx = i; arg = a; typ = t;
        start = 1'b1;
        sd_tick = with_tick;
        step();
        start = 1'b0;
        sd_tick = 1'b0;
    endtask

    // 48 bit ticks captured MSB first, plus the tick that releases the line.
    task automatic capture(output logic [47:0] s);
        s = '0;
        for (int i = 0; i < 48; i++) begin
            tick(1'b1);
            s = {s[46:0], cmd_out};
        end
        tick(1'b1);
    endtask

    task automatic reply48(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) tick(f[i]);
        cmd_in = 1'b1;
    endtask

    task automatic gap_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    function automatic logic [6:0] crc7_of(input logic [119:0] d);
        logic [126:0] m;
        m = {d, 7'b0};
        for (int i = 126; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    logic [47:0]  s;
    logic [119:0] content;
    logic [135:0] frame;
    int           at;
    int           dc;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; sd_tick = 1'b0; cmd_in = 1'b1;
        idx = '0; arg = '0; typ = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_ctrl", 136'({busy, done, cmd_oe, cmd_out}), 136'(4'b0001));
        check("reset_flags", 136'({t_err, c_err, e_err}), 136'(3'b000));
        check("reset_resp", 136'(resp), 136'(0));

        // CMD0, no response; start coincides with a tick
        start_cmd(6'd0, 32'h0, 2'd0, 1'b1);
        check("cmd0_accept", 136'({busy, cmd_oe, cmd_out}), 136'(3'b111));
        capture(s);
        check("cmd0_stream", 136'(s), 136'(48'h400000000095));
        check("cmd0_oe_off", 136'({cmd_oe, cmd_out}), 136'(2'b01));
        gap_ticks(7);
        check("cmd0_gap7", 136'({done, busy}), 136'(2'b01));
        tick(1'b1);
        check("cmd0_done", 136'({done, busy}), 136'(2'b10));
        check("cmd0_flags", 136'({t_err, c_err, e_err}), 136'(3'b000));

        // CMD8 with a good R7 reply
        start_cmd(6'd8, 32'h000001AA, 2'd1, 1'b0);
        capture(s);
        check("cmd8_stream", 136'(s), 136'(48'h48000001AA87));
        gap_ticks(2);
        reply48(48'h08000001AA13);
        gap_ticks(7);
        check("cmd8_gap7", 136'(done), 136'(0));
        tick(1'b1);
        check("cmd8_done", 136'(done), 136'(1));
        check("cmd8_resp", 136'(resp), 136'(120'h1AA));
        check("cmd8_flags", 136'({t_err, c_err, e_err}), 136'(3'b000));

        // CMD8 with a corrupted CRC byte
        start_cmd(6'd8, 32'h000001AA, 2'd1, 1'b0);
        capture(s);
        gap_ticks(1);
        reply48(48'h08000001AA15);
        gap_ticks(8);
        check("crcbad_done", 136'(done), 136'(1));
        check("crcbad_flags", 136'({t_err, c_err, e_err}), 136'(3'b010));
        check("crcbad_resp", 136'(resp), 136'(120'h1AA));

        // start and abort together: abort wins, flags untouched
        idx = 6'd1; typ = 2'd0;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("startabort_ctrl", 136'({busy, cmd_oe}), 136'(2'b00));
        check("startabort_flags", 136'({t_err, c_err, e_err}), 136'(3'b010));

        // CMD55 with no reply: timeout
        start_cmd(6'd55, 32'h0, 2'd1, 1'b0);
        check("cmd55_flags_clr", 136'({t_err, c_err, e_err}), 136'(3'b000));
        capture(s);
        check("cmd55_stream", 136'(s), 136'(48'h770000000065));
        at = 0;
        for (int i = 1; i <= 100; i++) begin
            tick(1'b1);
            if (done) begin
                at = i;
                break;
            end
        end
        check("timeout_done_tick", 136'(at), 136'(72));
        check("timeout_flags", 136'({t_err, c_err, e_err}), 136'(3'b100));
        check("timeout_resp_hold", 136'(resp), 136'(120'h1AA));

        // CMD2 with R136 reply; start pulsed mid-reception must be ignored
        content = 120'h0123456789ABCDEFFEDCBA98765432;
        frame   = {8'h3F, content, crc7_of(content), 1'b1};
        start_cmd(6'd2, 32'h0, 2'd2, 1'b0);
        capture(s);
        check("cmd2_stream", 136'(s), 136'(48'h42000000004D));
        tick(1'b1);
        for (int i = 135; i >= 0; i--) begin
            tick(frame[i]);
            if (i == 70) begin
                idx = 6'd0; typ = 2'd0;
                start = 1'b1;
                step();
                start = 1'b0;
                check("recv_start_ignored", 136'({busy, cmd_oe}), 136'(2'b10));
            end
        end
        cmd_in = 1'b1;
        gap_ticks(8);
        check("r136_done", 136'(done), 136'(1));
        check("r136_resp", 136'(resp), 136'(content));
        check("r136_flags", 136'({t_err, c_err, e_err}), 136'(3'b000));

        // abort while SEND is on bit 20
        start_cmd(6'd17, 32'h00001234, 2'd1, 1'b0);
        repeat (20) tick(1'b1);
        check("pre_abort_oe", 136'({busy, cmd_oe}), 136'(2'b11));
        dc = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_ctrl", 136'({busy, cmd_oe, cmd_out}), 136'(3'b001));
        gap_ticks(12);
        check("abort_no_done", 136'(done_cnt), 136'(dc));
        check("abort_flags", 136'({t_err, c_err, e_err}), 136'(3'b000));

        // reset in the middle of a reply
        start_cmd(6'd9, 32'h0, 2'd1, 1'b0);
        capture(s);
        tick(1'b1);
        for (int i = 47; i >= 38; i--) tick(frame[i + 88]);
        check("pre_reset_busy", 136'(busy), 136'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrx_reset_ctrl", 136'({busy, done, cmd_oe, cmd_out}), 136'(4'b0001));
        check("midrx_reset_flags", 136'({t_err, c_err, e_err}), 136'(3'b000));
        check("midrx_reset_resp", 136'(resp), 136'(0));

        // fresh command after reset
        cmd_in = 1'b1;
        start_cmd(6'd0, 32'h0, 2'd0, 1'b0);
        capture(s);
        check("post_reset_stream", 136'(s), 136'(48'h400000000095));
        gap_ticks(8);
        check("post_reset_done", 136'({done, busy}), 136'(2'b10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
